// File: rtl/neo_pkg.sv
// neo_pkg: shared definitions for the NeoPixel frame path.
//   - scheduler state encodings (also driven out on VERBOSE_STATE)
//   - pixel width and the default reset-gap length at 10 MHz
//   - bit-timing constants shared with the serializer (10 MHz clock,
//     12 clocks per 1.2 us bit, 24 bits per pixel = 288 clocks)
// No ports.
package neo_pkg;

  localparam int NEO_PIXEL_W            = 24;
  localparam int NEO_RESET_CYCLES_10MHZ = 500;

  localparam int NEO_BIT_CYCLES   = 12;
  localparam int NEO_T0H_CYCLES   = 4;
  localparam int NEO_T1H_CYCLES   = 8;
  localparam int NEO_PIXEL_CYCLES = NEO_PIXEL_W * NEO_BIT_CYCLES;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_OFFER     = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_GAP       = 3'd5
  } neo_state_e;

  // High time of one encoded bit; the serializer uses this to shape NEO_DATA.
  function automatic int neo_bit_high_cycles(input logic bit_val);
    return bit_val ? NEO_T1H_CYCLES : NEO_T0H_CYCLES;
  endfunction

endpackage

// File: rtl/neo_frame_scheduler_if.sv
// neo_frame_scheduler_if: buffer read port plus pixel stream to the
// serializer.
//   master : scheduler side (drives BUF_RD/BUF_ADDR, PIX_DATA/PIX_VALID)
//   slave  : buffer RAM + serializer side (drives BUF_DATA, PIX_READY,
//            SER_BUSY)
// Signals:
//   BUF_RD     read strobe, BUF_ADDR read address
//   BUF_DATA   read data, valid the cycle after BUF_RD
//   PIX_DATA   24-bit BRG pixel, PIX_VALID/PIX_READY handshake
//   SER_BUSY   serializer still shifting bits
interface neo_frame_scheduler_if #(
  parameter int PIX_ADDR_W = 8
);
  import neo_pkg::*;

  logic                   BUF_RD;
  logic [PIX_ADDR_W-1:0]  BUF_ADDR;
  logic [NEO_PIXEL_W-1:0] BUF_DATA;
  logic [NEO_PIXEL_W-1:0] PIX_DATA;
  logic                   PIX_VALID;
  logic                   PIX_READY;
  logic                   SER_BUSY;

  modport master (
    output BUF_RD,
    output BUF_ADDR,
    input  BUF_DATA,
    output PIX_DATA,
    output PIX_VALID,
    input  PIX_READY,
    input  SER_BUSY
  );

  modport slave (
    input  BUF_RD,
    input  BUF_ADDR,
    output BUF_DATA,
    input  PIX_DATA,
    input  PIX_VALID,
    output PIX_READY,
    output SER_BUSY
  );

endinterface

// File: rtl/neo_reset_timer.sv
// neo_reset_timer: up-counter for the NeoPixel low reset gap.
// Ports:
//   CLK_10MHZ  clock
//   RST_N      asynchronous active-low reset
//   load       clear the count to 0 (wins over en)
//   en         advance the count by one per clock
//   done       count has reached CYCLES-1 (last cycle of the gap)
// The count parks at CYCLES-1 so done stays stable if the owner lingers.
module neo_reset_timer #(
  parameter int CYCLES = 500,
  parameter int CNT_W  = 10
) (
  input  logic CLK_10MHZ,
  input  logic RST_N,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/neo_frame_scheduler.sv
// neo_frame_scheduler: sequences one NeoPixel frame. Reads CFG_PIXEL_COUNT
// 24-bit words from the pixel buffer, hands each to the serializer over
// PIX_VALID/PIX_READY, waits for the serializer to finish, then holds the
// RESET_CYCLES low gap and either restarts (CFG_CONTINUOUS) or idles.
// Ports:
//   CLK_10MHZ, RST_N     clock, asynchronous active-low reset
//   START                one-cycle frame request (IDLE only, count != 0)
//   CFG_PIXEL_COUNT      pixels per frame, latched at frame start
//   CFG_CONTINUOUS       restart after the gap, sampled on its last cycle
//   ABORT                (only with NEO_SCHED_ABORT_EN) cut the frame short
//   bus                  neo_frame_scheduler_if.master (buffer + pixel stream)
//   BUSY                 any state other than IDLE
//   FRAME_DONE           one-cycle pulse on the last gap cycle
//   VERBOSE_STATE        current state encoding
// Build option: define NEO_SCHED_ABORT_EN to add the ABORT input.
//
// state      | meaning
// IDLE       | waiting for START
// FETCH      | BUF_RD for pixel idx
// WAIT_DATA  | buffer returns data, captured into PIX_DATA
// OFFER      | PIX_VALID high until the serializer takes the pixel
// DRAIN      | waiting for the serializer to finish shifting
// GAP        | low reset gap, FRAME_DONE on its last cycle
module neo_frame_scheduler
  import neo_pkg::*;
#(
  parameter int PIX_ADDR_W   = 8,
  parameter int RESET_CYCLES = NEO_RESET_CYCLES_10MHZ,
  parameter int RESET_CNT_W  = 10
) (
  input  logic                  CLK_10MHZ,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [PIX_ADDR_W-1:0] CFG_PIXEL_COUNT,
  input  logic                  CFG_CONTINUOUS,
`ifdef NEO_SCHED_ABORT_EN
  input  logic                  ABORT,
`endif
  neo_frame_scheduler_if.master bus,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic [2:0]            VERBOSE_STATE
);

  neo_state_e             state_q, state_d;
  logic [PIX_ADDR_W-1:0]  idx_q, idx_d;
  logic [PIX_ADDR_W-1:0]  len_q, len_d;
  logic [NEO_PIXEL_W-1:0] pix_q, pix_d;

  logic cfg_ok;
  logic xfer;
  logic last_pix;
  logic abort_req;
  logic gap_load;
  logic gap_en;
  logic gap_done;

`ifdef NEO_SCHED_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  assign cfg_ok   = (CFG_PIXEL_COUNT != '0);
  assign xfer     = (state_q == ST_OFFER) && bus.PIX_READY;
  // len is never 0 once latched, so len-1 does not wrap.
  assign last_pix = (idx_q == (len_q - PIX_ADDR_W'(1)));

  neo_reset_timer #(
    .CYCLES (RESET_CYCLES),
    .CNT_W  (RESET_CNT_W)
  ) u_gap_timer (
    .CLK_10MHZ (CLK_10MHZ),
    .RST_N     (RST_N),
    .load      (gap_load),
    .en        (gap_en),
    .done      (gap_done)
  );

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    pix_d    = pix_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START && cfg_ok) begin
          len_d   = CFG_PIXEL_COUNT;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = abort_req ? ST_DRAIN : ST_WAIT_DATA;
      end

      ST_WAIT_DATA: begin
        if (abort_req) begin
          state_d = ST_DRAIN;
        end else begin
          pix_d   = bus.BUF_DATA;
          state_d = ST_OFFER;
        end
      end

      ST_OFFER: begin
        // A transfer coinciding with ABORT still counts; the frame just
        // ends after it.
        if (xfer) begin
          if (last_pix || abort_req) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d   = idx_q + PIX_ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end else if (abort_req) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!bus.SER_BUSY) begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end
      end

      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_done) begin
          if (CFG_CONTINUOUS && cfg_ok) begin
            len_d   = CFG_PIXEL_COUNT;
            idx_d   = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.BUF_RD    = (state_q == ST_FETCH);
  assign bus.BUF_ADDR  = idx_q;
  assign bus.PIX_DATA  = pix_q;
  assign bus.PIX_VALID = (state_q == ST_OFFER);

  assign BUSY          = (state_q != ST_IDLE);
  assign FRAME_DONE    = (state_q == ST_GAP) && gap_done;
  assign VERBOSE_STATE = state_q;

endmodule

// File: tb/tb_neo_frame_scheduler.sv
module tb_neo_frame_scheduler;
  import neo_pkg::*;

  localparam int AW = 8;
  localparam int RC = NEO_RESET_CYCLES_10MHZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cfg_cont = 1'b0;
  logic [AW-1:0] cfg_count = '0;
`ifdef NEO_SCHED_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy;
  logic          frame_done;
  logic [2:0]    vstate;

  neo_frame_scheduler_if #(.PIX_ADDR_W(AW)) bus_if ();

  neo_frame_scheduler #(
    .PIX_ADDR_W   (AW),
    .RESET_CYCLES (RC),
    .RESET_CNT_W  (10)
  ) dut (
    .CLK_10MHZ       (clk),
    .RST_N           (rst_n),
    .START           (start),
    .CFG_PIXEL_COUNT (cfg_count),
    .CFG_CONTINUOUS  (cfg_cont),
`ifdef NEO_SCHED_ABORT_EN
    .ABORT           (abort),
`endif
    .bus             (bus_if),
    .BUSY            (busy),
    .FRAME_DONE      (frame_done),
    .VERBOSE_STATE   (vstate)
  );

  always #50 clk = ~clk;

  // pixel buffer: registered read, data valid the cycle after BUF_RD
  logic [23:0] mem [256];
  always @(posedge clk) if (bus_if.BUF_RD) bus_if.BUF_DATA <= mem[bus_if.BUF_ADDR];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // observation of the DUT, compared later against expected frames
  int          addr_q[$];
  logic [23:0] pix_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_valid_cyc = -1;
  int          stable_viol = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data = '0;
  logic        rand_ready = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus_if.BUF_RD) addr_q.push_back(int'(bus_if.BUF_ADDR));
      if (bus_if.PIX_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (!bus_if.PIX_VALID || bus_if.PIX_DATA != prev_data)) stable_viol++;
      if (bus_if.PIX_VALID && bus_if.PIX_READY) pix_q.push_back(bus_if.PIX_DATA);
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus_if.PIX_VALID && !bus_if.PIX_READY;
      prev_data  = bus_if.PIX_DATA;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bus_if.PIX_READY = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk);
    #1 start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drop_ser_busy(output int fall);
    @(posedge clk);
    #1 bus_if.SER_BUSY = 1'b0;
    fall = cyc;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
    int k = 0;
    while (vstate !== s && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 32'(vstate === s), 1);
  endtask

  task automatic wait_pix(input int n, input int limit, input string tag);
    int k = 0;
    while (pix_q.size() < n && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 32'(pix_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int limit, input string tag);
    int k = 0;
    while (done_cnt < n && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 32'(done_cnt >= n), 1);
  endtask

  task automatic clear_obs();
    addr_q.delete();
    pix_q.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
  endtask

  initial begin
    int s;
    int fall;
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    bus_if.PIX_READY = 1'b0;
    bus_if.SER_BUSY  = 1'b0;

    // reset state
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(vstate), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_buf_rd", 32'(bus_if.BUF_RD), 0);
    check("rst_addr", 32'(bus_if.BUF_ADDR), 0);
    check("rst_valid", 32'(bus_if.PIX_VALID), 0);
    check("rst_data", 32'(bus_if.PIX_DATA), 0);
    rst_n = 1'b1;
    tick(2);

    // single two-pixel frame, serializer always ready
    clear_obs();
    mem[0] = 24'hff00d5;
    mem[1] = 24'h0000ff;
    cfg_count = 8'd2;
    bus_if.PIX_READY = 1'b1;
    bus_if.SER_BUSY  = 1'b1;
    pulse_start(s);
    wait_pix(2, 40, "single_pix_timeout");
    check("single_latency", 32'(first_valid_cyc - s), 3);
    check("single_naddr", 32'(addr_q.size()), 2);
    check("single_addr0", 32'(addr_q[0]), 0);
    check("single_addr1", 32'(addr_q[1]), 1);
    check("single_pix0", 32'(pix_q[0]), 32'h00ff00d5);
    check("single_pix1", 32'(pix_q[1]), 32'h000000ff);
    tick($urandom_range(3, 30));
    check("single_drain", 32'(vstate), 32'(ST_DRAIN));
    drop_ser_busy(fall);
    wait_done(1, RC + 50, "single_done_timeout");
    check("single_gap_len", 32'(done_cyc - fall), RC);
    tick(2);
    check("single_idle", 32'(vstate), 0);
    check("single_busy", 32'(busy), 0);

    // backpressure: 20 stalled cycles in OFFER
    clear_obs();
    stable_viol = 0;
    cfg_count = 8'd1;
    bus_if.PIX_READY = 1'b0;
    bus_if.SER_BUSY  = 1'b1;
    pulse_start(s);
    wait_state(3'(ST_OFFER), 20, "bp_offer_timeout");
    tick(20);
    check("bp_valid_held", 32'(bus_if.PIX_VALID), 1);
    check("bp_data_held", 32'(bus_if.PIX_DATA), 32'(mem[0]));
    check("bp_no_xfer", 32'(pix_q.size()), 0);
    bus_if.PIX_READY = 1'b1;
    tick(1);
    bus_if.PIX_READY = 1'b0;
    tick(3);
    check("bp_one_xfer", 32'(pix_q.size()), 1);
    check("bp_xfer_data", 32'(pix_q[0]), 32'(mem[0]));
    check("bp_stable", 32'(stable_viol), 0);
    check("bp_drain", 32'(vstate), 32'(ST_DRAIN));
    drop_ser_busy(fall);
    wait_done(1, RC + 50, "bp_done_timeout");
    check("bp_gap_len", 32'(done_cyc - fall), RC);

    // START with zero count is ignored
    tick(3);
    clear_obs();
    cfg_count = 8'd0;
    pulse_start(s);
    tick(5);
    check("zero_busy", 32'(busy), 0);
    check("zero_state", 32'(vstate), 0);
    check("zero_noread", 32'(addr_q.size()), 0);

    // START during GAP is ignored
    cfg_count = 8'd2;
    bus_if.PIX_READY = 1'b1;
    bus_if.SER_BUSY  = 1'b0;
    pulse_start(s);
    wait_state(3'(ST_GAP), 40, "gapstart_gap_timeout");
    tick(5);
    pulse_start(s);
    wait_done(1, RC + 50, "gapstart_done_timeout");
    tick(40);
    check("gapstart_ndone", 32'(done_cnt), 1);
    check("gapstart_idle", 32'(vstate), 0);
    check("gapstart_nread", 32'(addr_q.size()), 2);

    // continuous mode, cleared during the second frame
    clear_obs();
    for (int i = 0; i < 3; i++) mem[i] = 24'($urandom);
    cfg_count = 8'd3;
    cfg_cont = 1'b1;
    rand_ready = 1'b1;
    pulse_start(s);
    wait_done(1, RC + 200, "cont_done1_timeout");
    wait_pix(4, 100, "cont_pix4_timeout");
    cfg_cont = 1'b0;
    wait_done(2, RC + 200, "cont_done2_timeout");
    tick(RC + 50);
    rand_ready = 1'b0;
    bus_if.PIX_READY = 1'b1;
    check("cont_ndone", 32'(done_cnt), 2);
    check("cont_idle", 32'(vstate), 0);
    check("cont_npix", 32'(pix_q.size()), 6);
    for (int i = 0; i < 6 && i < pix_q.size(); i++) begin
      check("cont_pix", 32'(pix_q[i]), 32'(mem[i % 3]));
      check("cont_addr", 32'(addr_q[i]), 32'(i % 3));
    end

    // asynchronous reset in the middle of OFFER
    clear_obs();
    cfg_count = 8'd4;
    bus_if.PIX_READY = 1'b0;
    bus_if.SER_BUSY  = 1'b1;
    pulse_start(s);
    wait_state(3'(ST_OFFER), 20, "arst_offer_timeout");
    @(posedge clk);
    #20 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus_if.PIX_VALID), 0);
    check("arst_buf_rd", 32'(bus_if.BUF_RD), 0);
    check("arst_data", 32'(bus_if.PIX_DATA), 0);
    check("arst_addr", 32'(bus_if.BUF_ADDR), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_state", 32'(vstate), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    clear_obs();
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    cfg_count = 8'd2;
    bus_if.PIX_READY = 1'b1;
    pulse_start(s);
    wait_pix(2, 40, "arst_pix_timeout");
    check("arst_latency", 32'(first_valid_cyc - s), 3);
    check("arst_addr0", 32'(addr_q[0]), 0);
    check("arst_addr1", 32'(addr_q[1]), 1);
    check("arst_pix0", 32'(pix_q[0]), 32'(mem[0]));
    check("arst_pix1", 32'(pix_q[1]), 32'(mem[1]));
    drop_ser_busy(fall);
    wait_done(1, RC + 50, "arst_done_timeout");
    check("arst_gap_len", 32'(done_cyc - fall), RC);

`ifdef NEO_SCHED_ABORT_EN
    // abort while pixel 1 of 4 is offered
    tick(3);
    clear_obs();
    for (int i = 0; i < 4; i++) mem[i] = 24'($urandom);
    cfg_count = 8'd4;
    bus_if.PIX_READY = 1'b0;
    bus_if.SER_BUSY  = 1'b1;
    pulse_start(s);
    wait_state(3'(ST_OFFER), 20, "abort_offer0_timeout");
    bus_if.PIX_READY = 1'b1;
    tick(1);
    bus_if.PIX_READY = 1'b0;
    wait_state(3'(ST_OFFER), 20, "abort_offer1_timeout");
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_drain", 32'(vstate), 32'(ST_DRAIN));
    check("abort_valid", 32'(bus_if.PIX_VALID), 0);
    tick(10);
    check("abort_nread", 32'(addr_q.size()), 2);
    check("abort_npix", 32'(pix_q.size()), 1);
    check("abort_pix0", 32'(pix_q[0]), 32'(mem[0]));
    drop_ser_busy(fall);
    wait_done(1, RC + 50, "abort_done_timeout");
    check("abort_gap_len", 32'(done_cyc - fall), RC);
    tick(2);
    check("abort_idle", 32'(vstate), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
